sobel_avst_source: RTL and testbench

Avalon-ST source that streams the finished Sobel edge image out of the accelerator. Once the datapath signals a processed frame, the block walks the gradient image in raster order and pulls one pixel per cycle. It buffers pixels in a 2-entry FIFO and presents them on a ready/valid source with start-of-packet and end-of-packet framing. It is the transmit-side counterpart of the pixel-input sink that feeds the datapath.

---
 rtl/sobel_avst_source_pkg.sv | 37 +++
 rtl/sobel_avst_source_sync_fifo2.sv | 69 ++++++
 rtl/sobel_avst_source.sv | 151 +++++++++++++++
 tb/tb_sobel_avst_source.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_avst_source_pkg.sv
// ----------------------------------------------------------------------------
// sobel_avst_source_pkg
// Shared types for the Sobel edge-image Avalon-ST source:
//   - streamState_t : frame transfer state (IDLE / STREAM / DONE)
//   - beatFlags_t   : packet framing bits that travel with every pixel beat
//   - counterWidth  : width of a counter that must hold 0..pixelCount
// The data field of a FIFO entry depends on the DATA_WIDTH parameter of the
// instantiating block, so the full entry struct is assembled there from
// beatFlags_t plus the pixel field.
// ----------------------------------------------------------------------------
package sobel_avst_source_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } streamState_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } beatFlags_t;

    localparam int FLAG_WIDTH = $bits(beatFlags_t);

    // A counter that must reach pixelCount itself (one past the last index)
    // needs clog2(pixelCount + 1) bits; never return a zero-width counter.
    function automatic int counterWidth(input int pixelCount);
        int width;
        width = $clog2(pixelCount + 1);
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sobel_avst_source_sync_fifo2.sv
// ----------------------------------------------------------------------------
// sync_fifo2
// Two-entry synchronous FIFO with same-cycle push and pop.
// Ports:
//   clk_i   in          : clock, rising edge
//   rst_i   in          : synchronous active-high reset, empties the FIFO
//   push    in          : write wrData (accepted when not full, or when a
//                         pop in the same cycle frees a slot)
//   pop     in          : drop the head entry (ignored when empty)
//   wrData  in  [WIDTH] : entry to write
//   rdData  out [WIDTH] : head entry, valid while empty is low
//   full    out         : both slots occupied
//   empty   out         : no entries stored
// ----------------------------------------------------------------------------
module sync_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wrPtr;
    logic             rdPtr;
    logic [1:0]       count;
    logic             doPush;
    logic             doPop;

    // A pop is only real when something is stored; a push into a full FIFO
    // is only legal when that same-cycle pop frees the head slot.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    assign full   = (count == 2'd2);
    assign empty  = (count == 2'd0);
    assign rdData = mem[rdPtr];

    // Storage, pointers and occupancy. Storage is cleared on reset so the
    // head output reads as zero straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= wrData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sobel_avst_source.sv
// ----------------------------------------------------------------------------
// sobel_avst_source
// Streams the finished Sobel gradient image out as one Avalon-ST packet.
// After start_i the block reads the datapath one pixel per cycle in raster
// order, buffers pixels in a 2-entry FIFO and presents them with SOP on the
// first pixel and EOP on the last.
// Ports:
//   clk_i        in               : clock, rising edge
//   rst_i        in               : synchronous active-high reset
//   start_i      in               : pulse, gradient image complete
//   Pixel_i      in  [DATA_WIDTH] : datapath pixel at current read index
//   pixelInc_o   out              : advance datapath read index (pixel taken)
//   busy_o       out              : frame transfer in progress
//   frameDone_o  out              : pulse one cycle after EOP is accepted
//   avst_data_o  out [DATA_WIDTH] : stream data
//   avst_valid_o out              : stream valid
//   avst_ready_i in               : sink ready, ready latency 0
//   avst_sop_o   out              : start of packet
//   avst_eop_o   out              : end of packet
// ----------------------------------------------------------------------------
module sobel_avst_source
    import sobel_avst_source_pkg::*;
#(
    parameter int OUT_X_SIZE = 98,
    parameter int OUT_Y_SIZE = 98,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] Pixel_i,
    output logic                  pixelInc_o,
    output logic                  busy_o,
    output logic                  frameDone_o,
    output logic [DATA_WIDTH-1:0] avst_data_o,
    output logic                  avst_valid_o,
    input  logic                  avst_ready_i,
    output logic                  avst_sop_o,
    output logic                  avst_eop_o
);

    localparam int PIXEL_COUNT = OUT_X_SIZE * OUT_Y_SIZE;
    localparam int CNT_WIDTH   = counterWidth(PIXEL_COUNT);

    localparam logic [CNT_WIDTH-1:0] LAST_INDEX = CNT_WIDTH'(PIXEL_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] FRAME_END  = CNT_WIDTH'(PIXEL_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        beatFlags_t            flags;
    } fifoEntry_t;

    streamState_t         state;
    logic [CNT_WIDTH-1:0] fetchCount;
    logic [CNT_WIDTH-1:0] sendCount;

    fifoEntry_t pushEntry;
    fifoEntry_t headEntry;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       popFire;
    logic       fetchFire;

    // A beat leaves whenever the head is valid and the sink is ready.
    assign popFire = ~fifoEmpty & avst_ready_i;

    // Fetch while pixels remain and a slot is free; a pop this cycle counts
    // as a free slot so a full FIFO keeps streaming without a bubble.
    assign fetchFire = (state == STREAM) &&
                       (fetchCount < FRAME_END) &&
                       (~fifoFull || popFire);

    assign pixelInc_o = fetchFire;

    // Framing is decided at fetch time from the fetch index, so SOP and EOP
    // each land on exactly one beat (both on the same beat for a 1x1 image).
    always_comb begin
        pushEntry           = '0;
        pushEntry.data      = Pixel_i;
        pushEntry.flags.sop = (fetchCount == '0);
        pushEntry.flags.eop = (fetchCount == LAST_INDEX);
    end

    sync_fifo2 #(
        .WIDTH($bits(fifoEntry_t))
    ) beatFifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (fetchFire),
        .pop    (popFire),
        .wrData (pushEntry),
        .rdData (headEntry),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // Stream outputs come straight from the FIFO head. The framing bits are
    // qualified with valid because a drained FIFO still holds stale entries.
    assign avst_valid_o = ~fifoEmpty;
    assign avst_data_o  = headEntry.data;
    assign avst_sop_o   = ~fifoEmpty & headEntry.flags.sop;
    assign avst_eop_o   = ~fifoEmpty & headEntry.flags.eop;

    // Frame control: counters plus registered busy/frameDone. A frame ends
    // when the EOP beat is accepted; start_i outside IDLE is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            fetchCount  <= '0;
            sendCount   <= '0;
            busy_o      <= 1'b0;
            frameDone_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frameDone_o <= 1'b0;
                    if (start_i) begin
                        fetchCount <= '0;
                        sendCount  <= '0;
                        busy_o     <= 1'b1;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (fetchFire) begin
                        fetchCount <= fetchCount + CNT_ONE;
                    end
                    if (popFire && (sendCount != LAST_INDEX)) begin
                        sendCount <= sendCount + CNT_ONE;
                    end
                    if (popFire && headEntry.flags.eop) begin
                        busy_o      <= 1'b0;
                        frameDone_o <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    frameDone_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy_o      <= 1'b0;
                    frameDone_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_avst_source.sv
// ----------------------------------------------------------------------------
// tb_sobel_avst_source
// Scoreboard bench for sobel_avst_source: a 4x4 instance exercises normal,
// backpressured, restarted, reset and back-to-back frames; a 1x1 instance
// covers the single-beat packet. Stimulus tasks push expected beats into a
// queue; negedge monitors pop and compare whenever a beat is accepted.
// ----------------------------------------------------------------------------
module tb_sobel_avst_source;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b1;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;
    logic       ready4 = 1'b1;
    logic       ready1 = 1'b1;
    logic [7:0] pix4;
    logic [7:0] pix1 = 8'h5A;

    logic       pixInc4, busy4, done4, valid4, sop4, eop4;
    logic [7:0] data4;
    logic       pixInc1, busy1, done1, valid1, sop1, eop1;
    logic [7:0] data1;

    int cyc = 0;
    int assertCount = 0;
    int failCount = 0;

    beat_t expQ4[$];
    beat_t expQ1[$];
    beat_t expBeat4;
    beat_t expBeat1;
    beat_t prevBeat4;
    logic  prevHeld4 = 1'b0;

    int occ4 = 0, pixTotal4 = 0, beatTotal4 = 0, doneCount4 = 0;
    int lastDoneCyc4 = 0, lastSopCyc4 = 0, lastBeatCyc4 = 0;
    int beatTotal1 = 0, doneCount1 = 0, beatCyc1 = 0, doneCyc1 = 0;

    int readyMode = 0;
    int patCnt = 0;
    logic [7:0] readIdx = 8'd0;

    sobel_avst_source #(.OUT_X_SIZE(4), .OUT_Y_SIZE(4), .DATA_WIDTH(8)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .Pixel_i(pix4),
        .pixelInc_o(pixInc4), .busy_o(busy4), .frameDone_o(done4),
        .avst_data_o(data4), .avst_valid_o(valid4), .avst_ready_i(ready4),
        .avst_sop_o(sop4), .avst_eop_o(eop4));

    sobel_avst_source #(.OUT_X_SIZE(1), .OUT_Y_SIZE(1), .DATA_WIDTH(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .Pixel_i(pix1),
        .pixelInc_o(pixInc1), .busy_o(busy1), .frameDone_o(done1),
        .avst_data_o(data1), .avst_valid_o(valid1), .avst_ready_i(ready1),
        .avst_sop_o(sop1), .avst_eop_o(eop1));

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: the pixel value equals its raster index, and the
    // read index rewinds whenever no transfer is in progress.
    always @(posedge clk) begin
        if (!busy4) readIdx <= 8'd0;
        else if (pixInc4) readIdx <= readIdx + 8'd1;
    end
    assign pix4 = readIdx;

    // Sink ready: mode 0 holds it high, mode 1 repeats 1,0,0.
    always @(posedge clk) begin
        #1;
        if (readyMode == 0) ready4 = 1'b1;
        else ready4 = ((patCnt % 3) == 0);
        patCnt = patCnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor for the 4x4 instance: stability under backpressure, beat
    // scoreboard, FIFO occupancy bound and frame-done bookkeeping.
    always @(negedge clk) begin
        if (rst) begin
            occ4 = 0;
            prevHeld4 = 1'b0;
        end else begin
            if (prevHeld4) begin
                checkOutput("holdValid4", 32'(valid4), 32'd1);
                checkOutput("holdBeat4", 32'({data4, sop4, eop4}), 32'(prevBeat4));
            end
            if (pixInc4) begin
                pixTotal4++;
                occ4++;
            end
            if (valid4 && ready4) begin
                beatTotal4++;
                occ4--;
                lastBeatCyc4 = cyc;
                if (sop4) lastSopCyc4 = cyc;
                if (expQ4.size() == 0) begin
                    checkOutput("strayBeat4", 32'd1, 32'd0);
                end else begin
                    expBeat4 = expQ4.pop_front();
                    checkOutput("beat4", 32'({data4, sop4, eop4}), 32'(expBeat4));
                end
            end
            if (pixInc4) checkOutput("fifoBound4", 32'(occ4 <= 2), 32'd1);
            if (done4) begin
                doneCount4++;
                lastDoneCyc4 = cyc;
            end
            prevHeld4 = valid4 && !ready4;
            prevBeat4 = {data4, sop4, eop4};
        end
    end

    // Monitor for the 1x1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid1 && ready1) begin
                beatTotal1++;
                beatCyc1 = cyc;
                if (expQ1.size() == 0) begin
                    checkOutput("strayBeat1", 32'd1, 32'd0);
                end else begin
                    expBeat1 = expQ1.pop_front();
                    checkOutput("beat1", 32'({data1, sop1, eop1}), 32'(expBeat1));
                end
            end
            if (done1) begin
                doneCount1++;
                doneCyc1 = cyc;
            end
        end
    end

    // Queue one 4x4 frame (pixels 0..15) and pulse start for one cycle.
    task automatic applyStimulus(output int startCyc);
        beat_t b;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            b.data = 8'(i);
            b.sop  = (i == 0);
            b.eop  = (i == 15);
            expQ4.push_back(b);
        end
        start4   = 1'b1;
        startCyc = cyc;
        @(posedge clk);
        #1;
        start4 = 1'b0;
    endtask

    task automatic waitDone4(input int budget);
        int base;
        bit seen;
        base = doneCount4;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            #1;
            if (doneCount4 != base) seen = 1'b1;
        end
        if (!seen) checkOutput("doneTimeout4", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s, s2, p0, dc, bt;
        bit hit;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstValid", 32'(valid4), 32'd0);
        checkOutput("rstSop", 32'(sop4), 32'd0);
        checkOutput("rstEop", 32'(eop4), 32'd0);
        checkOutput("rstData", 32'(data4), 32'd0);
        checkOutput("rstBusy", 32'(busy4), 32'd0);
        checkOutput("rstDone", 32'(done4), 32'd0);
        checkOutput("rstPixInc", 32'(pixInc4), 32'd0);
        checkOutput("rstValid1", 32'(valid1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ready held high: gap-free frame with fixed latencies.
        $display("[TB] frame with ready high");
        p0 = pixTotal4;
        applyStimulus(s);
        waitDone4(100);
        checkOutput("sopCycle", 32'(lastSopCyc4), 32'(s + 2));
        checkOutput("eopCycle", 32'(lastBeatCyc4), 32'(s + 17));
        checkOutput("doneCycle", 32'(lastDoneCyc4), 32'(s + 18));
        checkOutput("pixCount", 32'(pixTotal4 - p0), 32'd16);
        checkOutput("queueEmpty", 32'(expQ4.size()), 32'd0);
        checkOutput("busyInDone", 32'(busy4), 32'd0);
        @(negedge clk);
        checkOutput("doneOnePulse", 32'(done4), 32'd0);

        // Backpressure pattern 1,0,0.
        $display("[TB] frame with backpressure");
        readyMode = 1;
        p0 = pixTotal4;
        applyStimulus(s);
        waitDone4(200);
        checkOutput("bpPixCount", 32'(pixTotal4 - p0), 32'd16);
        checkOutput("bpQueueEmpty", 32'(expQ4.size()), 32'd0);
        readyMode = 0;
        repeat (3) @(negedge clk);

        // Second start mid-frame must be ignored.
        $display("[TB] restart pulse mid-frame");
        p0 = pixTotal4;
        dc = doneCount4;
        applyStimulus(s);
        repeat (5) @(posedge clk);
        #1;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        waitDone4(100);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("ignStartDone", 32'(doneCount4 - dc), 32'd1);
        checkOutput("ignStartDoneCyc", 32'(lastDoneCyc4), 32'(s + 18));
        checkOutput("ignStartPix", 32'(pixTotal4 - p0), 32'd16);
        checkOutput("ignStartQueue", 32'(expQ4.size()), 32'd0);

        // Reset after five accepted beats, then a clean frame.
        $display("[TB] reset mid-frame");
        bt = beatTotal4;
        applyStimulus(s);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (beatTotal4 >= bt + 5) hit = 1'b1;
        end
        checkOutput("fiveBeats", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstValid", 32'(valid4), 32'd0);
        checkOutput("midRstSop", 32'(sop4), 32'd0);
        checkOutput("midRstEop", 32'(eop4), 32'd0);
        checkOutput("midRstData", 32'(data4), 32'd0);
        checkOutput("midRstBusy", 32'(busy4), 32'd0);
        checkOutput("midRstDone", 32'(done4), 32'd0);
        checkOutput("midRstPixInc", 32'(pixInc4), 32'd0);
        expQ4.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        p0 = pixTotal4;
        applyStimulus(s);
        waitDone4(100);
        checkOutput("postRstSop", 32'(lastSopCyc4), 32'(s + 2));
        checkOutput("postRstPix", 32'(pixTotal4 - p0), 32'd16);
        checkOutput("postRstQueue", 32'(expQ4.size()), 32'd0);

        // Back-to-back frames: start in the cycle after frameDone.
        $display("[TB] back-to-back frames");
        applyStimulus(s);
        waitDone4(100);
        checkOutput("b2bDone1", 32'(lastDoneCyc4), 32'(s + 18));
        applyStimulus(s2);
        waitDone4(100);
        checkOutput("b2bSop2", 32'(lastSopCyc4), 32'(s + 21));
        checkOutput("b2bDone2", 32'(lastDoneCyc4), 32'(s + 37));
        checkOutput("b2bQueue", 32'(expQ4.size()), 32'd0);

        // Single-pixel frame on the 1x1 instance.
        $display("[TB] 1x1 frame");
        @(posedge clk);
        #1;
        expQ1.push_back({8'h5A, 1'b1, 1'b1});
        start1 = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (doneCount1 != 0) hit = 1'b1;
        end
        checkOutput("oneDoneSeen", 32'(hit), 32'd1);
        checkOutput("oneBeatCyc", 32'(beatCyc1), 32'(s + 2));
        checkOutput("oneDoneCyc", 32'(doneCyc1), 32'(s + 3));
        checkOutput("oneBeatCount", 32'(beatTotal1), 32'd1);
        checkOutput("oneQueue", 32'(expQ1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
